// File: rtl/lpm_mult_pipe_pkg.sv
// Shared definitions for the LPM-style multiply-add.
//   rep_signed / rep_unsigned : legal LPM_REPRESENTATION strings
//   full_width()              : exact width F of dataa*datab + sum, including one guard bit
package lpm_mult_pipe_pkg;

  localparam string RepSigned   = "SIGNED";
  localparam string RepUnsigned = "UNSIGNED";

  // F = max(wa + wb, ws) + 1; wide enough that the multiply-add can never overflow.
  function automatic int unsigned full_width(int unsigned wa, int unsigned wb, int unsigned ws);
    int unsigned m;
    m = ((wa + wb) > ws) ? (wa + wb) : ws;
    return m + 1;
  endfunction

endpackage

// File: rtl/lpm_mult_pipe_stage.sv
// One pipeline register of the multiply-add delay line.
//   clock : rising-edge clock
//   aclr  : asynchronous active-low clear, wins over clken
//   clken : high loads d, low holds
//   d / q : data in / registered data out
module lpm_mult_pipe_stage #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clken,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      q_q <= '0;
    end else if (clken) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lpm_mult_pipe.sv
// Parameterized signed/unsigned multiply-add, result = dataa * datab + sum, with an optional
// LPM_PIPELINE-deep register delay line on the output.
//   clock  : rising-edge clock (unused when LPM_PIPELINE == 0)
//   aclr   : asynchronous active-low clear of all stages
//   clken  : clock enable, high advances every stage together
//   dataa  : multiplicand, LPM_WIDTHA bits
//   datab  : multiplier, LPM_WIDTHB bits
//   sum    : addend, LPM_WIDTHS bits
//   result : extended or MSB-truncated exact result, LPM_WIDTHP bits
module lpm_mult_pipe
  import lpm_mult_pipe_pkg::*;
#(
  parameter int unsigned LPM_WIDTHA         = 14,
  parameter int unsigned LPM_WIDTHB         = 14,
  parameter int unsigned LPM_WIDTHP         = 35,
  parameter int unsigned LPM_WIDTHS         = 35,
  parameter int unsigned LPM_PIPELINE       = 0,
  parameter string       LPM_REPRESENTATION = "SIGNED"
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clken,
  input  logic [LPM_WIDTHA-1:0] dataa,
  input  logic [LPM_WIDTHB-1:0] datab,
  input  logic [LPM_WIDTHS-1:0] sum,
  output logic [LPM_WIDTHP-1:0] result
);

  localparam int unsigned F = full_width(LPM_WIDTHA, LPM_WIDTHB, LPM_WIDTHS);
  // Anything other than "UNSIGNED" is two's complement.
  localparam bit IsSigned = (LPM_REPRESENTATION != RepUnsigned);

  logic            a_msb, b_msb, s_msb;
  logic [F-1:0]    a_ext, b_ext, s_ext;
  logic [F-1:0]    p_full;
  logic [LPM_WIDTHP-1:0] p_fmt;

  // Extension bit is the operand MSB when signed, zero when unsigned.
  assign a_msb = IsSigned & dataa[LPM_WIDTHA-1];
  assign b_msb = IsSigned & datab[LPM_WIDTHB-1];
  assign s_msb = IsSigned & sum[LPM_WIDTHS-1];

  assign a_ext = {{(F - LPM_WIDTHA){a_msb}}, dataa};
  assign b_ext = {{(F - LPM_WIDTHB){b_msb}}, datab};
  assign s_ext = {{(F - LPM_WIDTHS){s_msb}}, sum};

  // Modulo-2^F arithmetic is exact here: the true result always fits in F bits, so the low
  // F bits of the unsigned product equal the signed product as well.
  assign p_full = a_ext * b_ext + s_ext;

  // Output formatting: extend when wider than F, otherwise keep the top LPM_WIDTHP bits.
  if (LPM_WIDTHP > F) begin : g_ext
    assign p_fmt = {{(LPM_WIDTHP - F){IsSigned & p_full[F-1]}}, p_full};
  end else if (LPM_WIDTHP == F) begin : g_exact
    assign p_fmt = p_full;
  end else begin : g_trunc
    logic unused_low;
    assign p_fmt      = p_full[F-1 -: LPM_WIDTHP];
    assign unused_low = ^p_full[F-LPM_WIDTHP-1:0];
  end

  // Delay line.
  if (LPM_PIPELINE == 0) begin : g_comb
    logic unused_ctrl;
    assign result      = p_fmt;
    assign unused_ctrl = ^{clock, aclr, clken};
  end else begin : g_pipe
    logic [LPM_PIPELINE:0][LPM_WIDTHP-1:0] pipe;
    assign pipe[0] = p_fmt;
    for (genvar i = 0; i < LPM_PIPELINE; i++) begin : g_stage
      lpm_mult_pipe_stage #(
        .Width (LPM_WIDTHP)
      ) u_stage (
        .clock (clock),
        .aclr  (aclr),
        .clken (clken),
        .d     (pipe[i]),
        .q     (pipe[i+1])
      );
    end
    assign result = pipe[LPM_PIPELINE];
  end

endmodule

// File: tb/tb_lpm_mult_pipe.sv
module tb_lpm_mult_pipe;

  logic clock = 1'b0;
  logic aclr  = 1'b0;
  logic clken = 1'b1;

  always #5 clock = ~clock;

  // Combinational signed 14x14; sum width 34 makes F == 35 == result width (exact result).
  logic [13:0] ca, cb;
  logic [33:0] cs;
  logic [34:0] cr;
  // Combinational unsigned 14x14, sum 14, result 29 (== F).
  logic [13:0] ua, ub, us;
  logic [28:0] ur;
  // Combinational signed 8x8, sum 8, result 8: F = 17, result = P[16:9].
  logic [7:0]  ta, tb, ts, tr;
  // Pipelined (3 stages) signed 14x14, sum 34, result 35.
  logic [13:0] pa, pb;
  logic [33:0] ps;
  logic [34:0] pr;

  lpm_mult_pipe #(
    .LPM_WIDTHA(14), .LPM_WIDTHB(14), .LPM_WIDTHP(35), .LPM_WIDTHS(34),
    .LPM_PIPELINE(0), .LPM_REPRESENTATION("SIGNED")
  ) u_comb (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(ca), .datab(cb), .sum(cs), .result(cr)
  );

  lpm_mult_pipe #(
    .LPM_WIDTHA(14), .LPM_WIDTHB(14), .LPM_WIDTHP(29), .LPM_WIDTHS(14),
    .LPM_PIPELINE(0), .LPM_REPRESENTATION("UNSIGNED")
  ) u_uns (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(ua), .datab(ub), .sum(us), .result(ur)
  );

  lpm_mult_pipe #(
    .LPM_WIDTHA(8), .LPM_WIDTHB(8), .LPM_WIDTHP(8), .LPM_WIDTHS(8),
    .LPM_PIPELINE(0), .LPM_REPRESENTATION("SIGNED")
  ) u_trunc (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(ta), .datab(tb), .sum(ts), .result(tr)
  );

  lpm_mult_pipe #(
    .LPM_WIDTHA(14), .LPM_WIDTHB(14), .LPM_WIDTHP(35), .LPM_WIDTHS(34),
    .LPM_PIPELINE(3), .LPM_REPRESENTATION("SIGNED")
  ) u_pipe (
    .clock(clock), .aclr(aclr), .clken(clken), .dataa(pa), .datab(pb), .sum(ps), .result(pr)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact multiply-add, then keep the top wp of f bits (arithmetic shift) when wp < f.
  function automatic longint mac_ref(longint a, longint b, longint s, int f, int wp);
    longint p;
    p = a * b + s;
    if (wp >= f) return p;
    return p >>> (f - wp);
  endfunction

  function automatic logic [63:0] fit(longint v, int w);
    return 64'(v) & ((64'd1 << w) - 64'd1);
  endfunction

  // Pipeline model: contents of the three stages, oldest (visible at result) first.
  longint exp_q[$];
  longint cur_p;

  task automatic drive_pipe(input logic [13:0] a, input logic [13:0] b, input logic [33:0] s);
    pa = a;
    pb = b;
    ps = s;
    cur_p = mac_ref(longint'($signed(a)), longint'($signed(b)), longint'($signed(s)), 35, 35);
  endtask

  task automatic pipe_edge(input string tag);
    @(posedge clock);
    if (clken && aclr) begin
      exp_q.push_back(cur_p);
      void'(exp_q.pop_front());
    end
    #1;
    check_eq(tag, 64'(pr), fit(exp_q[0], 35));
  endtask

  initial begin
    ca = '0; cb = '0; cs = '0;
    ua = '0; ub = '0; us = '0;
    ta = '0; tb = '0; ts = '0;
    drive_pipe(14'd0, 14'd0, 34'd0);
    exp_q = '{0, 0, 0};

    // Reset state of the pipelined instance.
    #1;
    check_eq("pipe_reset", 64'(pr), 64'd0);
    @(negedge clock);
    aclr = 1'b1;

    // Directed combinational checks.
    ca = 14'd70;            cb = 14'd100;         cs = '0; #1;
    check_eq("comb_70x100", 64'(cr), fit(7000, 35));
    ca = 14'h2000;          cb = 14'h2000;        cs = '0; #1;
    check_eq("comb_min_x_min", 64'(cr), fit(67108864, 35));
    ca = 14'h2000;          cb = 14'd8191;        cs = '0; #1;
    check_eq("comb_min_x_max", 64'(cr), fit(-67100672, 35));
    ca = 14'd3;             cb = 14'h3ffb;        cs = 34'd100; #1;
    check_eq("comb_addend", 64'(cr), fit(85, 35));
    ca = '0;                cb = '0;              cs = '1; #1;
    check_eq("comb_sum_m1", 64'(cr), fit(-1, 35));
    ua = 14'd16383;         ub = 14'd16383;       us = '0; #1;
    check_eq("uns_max_x_max", 64'(ur), fit(268402689, 29));
    ta = 8'd64;             tb = 8'd64;           ts = '0; #1;
    check_eq("trunc_64x64", 64'(tr), fit(8, 8));
    ta = 8'hff;             tb = 8'd1;            ts = '0; #1;
    check_eq("trunc_m1x1", 64'(tr), fit(-1, 8));

    // Random combinational checks against the model.
    for (int i = 0; i < 40; i++) begin
      ca = 14'($urandom); cb = 14'($urandom); cs = 34'({$urandom, $urandom});
      ua = 14'($urandom); ub = 14'($urandom); us = 14'($urandom);
      ta = 8'($urandom);  tb = 8'($urandom);  ts = 8'($urandom);
      #1;
      check_eq("comb_rand", 64'(cr), fit(mac_ref(longint'($signed(ca)), longint'($signed(cb)),
                                                  longint'($signed(cs)), 35, 35), 35));
      check_eq("uns_rand", 64'(ur), fit(mac_ref(longint'(ua), longint'(ub), longint'(us),
                                                 29, 29), 29));
      check_eq("trunc_rand", 64'(tr), fit(mac_ref(longint'($signed(ta)), longint'($signed(tb)),
                                                   longint'($signed(ts)), 17, 8), 8));
    end

    // Pipelined random stream, clken high.
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      drive_pipe(14'($urandom), 14'($urandom), 34'({$urandom, $urandom}));
      pipe_edge("pipe_stream");
    end

    // Two held cycles; inputs keep changing but must not be captured.
    clken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_pipe(14'($urandom), 14'($urandom), 34'({$urandom, $urandom}));
      pipe_edge("pipe_hold");
    end
    clken = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_pipe(14'($urandom), 14'($urandom), 34'({$urandom, $urandom}));
      pipe_edge("pipe_resume");
    end

    // Asynchronous clear between edges with data in flight.
    #2;
    aclr = 1'b0;
    #1;
    exp_q = '{0, 0, 0};
    check_eq("pipe_aclr_async", 64'(pr), 64'd0);
    pipe_edge("pipe_aclr_held");
    #2;
    aclr = 1'b1;
    drive_pipe(14'($urandom_range(1, 8191)), 14'($urandom_range(1, 8191)), 34'd0);
    pipe_edge("pipe_post_rst1");
    drive_pipe(14'($urandom_range(1, 8191)), 14'($urandom_range(1, 8191)), 34'd0);
    pipe_edge("pipe_post_rst2");
    drive_pipe(14'($urandom_range(1, 8191)), 14'($urandom_range(1, 8191)), 34'd0);
    pipe_edge("pipe_post_rst3");
    check_eq("pipe_first_nonzero", 64'(pr != '0), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive_pipe(14'($urandom), 14'($urandom), 34'({$urandom, $urandom}));
      pipe_edge("pipe_tail");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
